// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: computes a-b one DIGIT-wide chunk per clock (LSB chunk first), reports diff and eq/gt/lt/overflow.
// Ports: clk/rst; start, a, b, signed_mode in; busy, done, diff, a_eq_b, a_gt_b, a_lt_b, overflow out.
// Latency: start sampled at edge k -> results and done on edge k+NCYC; start ignored while busy (no queuing).
module serial_magnitude_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             a_eq_b,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             overflow
);

  localparam int NCYC = WIDTH / DIGIT;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_r, b_r;
  logic             mode_r;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last;
  logic [DIGIT:0]   sum;
  logic [WIDTH-1:0] diff_nxt;
  logic             cin_msb;
  logic             ovf_nxt;
  logic             lt_nxt;
  logic             eq_nxt;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (state == CALC) && (cnt == CW'(NCYC - 1));

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

  // ---------------- Datapath ----------------
  // Operands are shifted right each cycle so the active chunk is always in
  // the low DIGIT bits; subtraction is a + ~b + 1 with the +1 as initial carry.
  assign sum = {1'b0, a_r[DIGIT-1:0]} + {1'b0, ~b_r[DIGIT-1:0]} + (DIGIT + 1)'(carry);

  // Working register collects finished chunks from the top down, so on the
  // last chunk the full difference is {current chunk, earlier chunks}.
  generate
    if (NCYC > 1) begin : g_multi
      logic [WIDTH-DIGIT-1:0] work;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                work <= '0;
        else if (state == CALC) work <= diff_nxt[WIDTH-1:DIGIT];
      end
      assign diff_nxt = {sum[DIGIT-1:0], work};
    end else begin : g_single
      assign diff_nxt = sum[DIGIT-1:0];
    end
  endgenerate

  // Carry into the MSB recovered from the MSB sum bit: s = a ^ ~b ^ cin.
  assign cin_msb = diff_nxt[WIDTH-1] ^ a_r[DIGIT-1] ^ ~b_r[DIGIT-1];
  assign ovf_nxt = mode_r & (cin_msb ^ sum[DIGIT]);
  assign lt_nxt  = mode_r ? (diff_nxt[WIDTH-1] ^ ovf_nxt) : ~sum[DIGIT];
  assign eq_nxt  = (diff_nxt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      mode_r <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_r    <= a;
      b_r    <= b;
      mode_r <= signed_mode;
      carry  <= 1'b1;
      cnt    <= '0;
    end else if (state == CALC) begin
      a_r   <= a_r >> DIGIT;
      b_r   <= b_r >> DIGIT;
      carry <= sum[DIGIT];
      cnt   <= cnt + CW'(1);
    end
  end

  // Results only change on the completing edge and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff     <= '0;
      a_eq_b   <= 1'b0;
      a_gt_b   <= 1'b0;
      a_lt_b   <= 1'b0;
      overflow <= 1'b0;
    end else if (last) begin
      diff     <= diff_nxt;
      a_eq_b   <= eq_nxt;
      a_gt_b   <= ~eq_nxt & ~lt_nxt;
      a_lt_b   <= lt_nxt;
      overflow <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed-vector bench for serial_magnitude_comparator (8/4 and 16/4 instances).
// Expected values are hand-computed constants in the stimulus calls.
// Inputs are driven and outputs sampled on the falling edge.
module tb_serial_magnitude_comparator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, mode8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, eq8, gt8, lt8, ov8;
  logic [7:0]  diff8;

  logic        start16 = 1'b0, mode16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, eq16, gt16, lt16, ov16;
  logic [15:0] diff16;

  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(4)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .signed_mode(mode8),
    .busy(busy8), .done(done8), .diff(diff8), .a_eq_b(eq8), .a_gt_b(gt8),
    .a_lt_b(lt8), .overflow(ov8)
  );

  serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .signed_mode(mode16),
    .busy(busy16), .done(done16), .diff(diff16), .a_eq_b(eq16), .a_gt_b(gt16),
    .a_lt_b(lt16), .overflow(ov16)
  );

  int nvec = 0;
  int nerr = 0;
  logic [7:0] last_diff8 = 8'h00;

  // Flag order {eq, gt, lt, ovf}
  localparam logic [3:0] F_EQ = 4'b1000, F_GT = 4'b0100, F_LT = 4'b0010,
                         F_LT_OV = 4'b0011, F_GT_OV = 4'b0101;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch on a falling edge, scramble inputs during CALC, wait for done.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic m, input logic [7:0] ediff, input logic [3:0] eflags);
    int n, bc;
    a8 = a; b8 = b; mode8 = m; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = ~a; b8 = b ^ 8'h5A; mode8 = ~m;
    n = 1; bc = 0;
    if (busy8) bc++;
    check({tag, "_hold"}, diff8, last_diff8);
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
      if (busy8) bc++;
    end
    check({tag, "_lat"}, n - 1, 2);
    check({tag, "_busy"}, bc, 2);
    check({tag, "_diff"}, diff8, ediff);
    check({tag, "_flags"}, {eq8, gt8, lt8, ov8}, eflags);
    last_diff8 = ediff;
    @(negedge clk);
    check({tag, "_pulse"}, {done8, busy8}, 2'b00);
  endtask

  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic m, input logic [15:0] ediff, input logic [3:0] eflags);
    int n;
    a16 = a; b16 = b; mode16 = m; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; a16 = ~a;
    n = 1;
    while (!done16 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n - 1, 4);
    check({tag, "_diff"}, diff16, ediff);
    check({tag, "_flags"}, {eq16, gt16, lt16, ov16}, eflags);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dc;
    #1;
    check("rst_busy_done", {busy8, done8}, 2'b00);
    check("rst_diff", diff8, 8'h00);
    check("rst_flags", {eq8, gt8, lt8, ov8}, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run8("zero",   8'h00, 8'h00, 1'b0, 8'h00, F_EQ);
    run8("u_gt",   8'h03, 8'h01, 1'b0, 8'h02, F_GT);
    run8("u_lt",   8'h02, 8'h04, 1'b0, 8'hFE, F_LT);
    run8("s_ovf",  8'h80, 8'h7F, 1'b1, 8'h01, F_LT_OV);
    run8("u_80",   8'h80, 8'h7F, 1'b0, 8'h01, F_GT);
    run8("s_neg",  8'hFE, 8'h01, 1'b1, 8'hFD, F_LT);
    run8("u_fe",   8'hFE, 8'h01, 1'b0, 8'hFD, F_GT);
    run8("s_gtov", 8'h7F, 8'h80, 1'b1, 8'hFF, F_GT_OV);
    run8("s_ones", 8'hFF, 8'hFF, 1'b1, 8'h00, F_EQ);
    run8("s_mneg", 8'h80, 8'h80, 1'b1, 8'h00, F_EQ);

    // Start re-asserted during CALC with new operands must be ignored.
    a8 = 8'h05; b8 = 8'h03; mode8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h09;
    @(negedge clk);
    start8 = 1'b0;
    dc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done8) begin
        dc++;
        check("ign_diff", diff8, 8'h02);
        check("ign_flags", {eq8, gt8, lt8, ov8}, F_GT);
      end
    end
    check("ign_count", dc, 1);

    // Start held high in the DONE cycle: back-to-back compare, no IDLE gap.
    a8 = 8'h10; b8 = 8'h20; mode8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 1;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b1_lat", n - 1, 2);
    check("b2b1_diff", diff8, 8'hF0);
    check("b2b1_flags", {eq8, gt8, lt8, ov8}, F_LT);
    a8 = 8'h20; b8 = 8'h10; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("b2b_gap", {busy8, done8}, 2'b10);
    n = 1;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b2_lat", n - 1, 2);
    check("b2b2_diff", diff8, 8'h10);
    check("b2b2_flags", {eq8, gt8, lt8, ov8}, F_GT);
    @(negedge clk);

    // Reset in the middle of CALC aborts asynchronously, no done follows.
    a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("abort_busy_pre", busy8, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {busy8, done8}, 2'b00);
    check("abort_diff", diff8, 8'h00);
    check("abort_flags", {eq8, gt8, lt8, ov8}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done8 || busy8) dc++;
    end
    check("abort_quiet", dc, 0);

    run16("w_ones", 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, F_EQ);
    run16("w_slt",  16'h1234, 16'h1235, 1'b1, 16'hFFFF, F_LT);
    run16("w_ugt",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, F_GT);
    run16("w_sov",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, F_LT_OV);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
